// File: rtl/utlb_walker.sv
//==============================================================================
// Module      : utlb_walker
// Description : Micro-TLB with a single-request lookup/refill walker.
//               A request is latched in IDLE and resolved in LOOKUP as one of:
//               user address error, unmapped window (direct offset mapping),
//               micro-TLB hit, or miss. A miss starts a refill handshake with
//               the main TLB. A found entry is installed round-robin and the
//               translation is then returned.
//               Each request produces exactly one single-cycle response.
// Ports       :
//   clk, res                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_vaddr/req_write/req_user  virtual address, store flag, user-mode flag
//   resp_valid                    one-cycle response strobe
//   resp_paddr/resp_io/resp_exc   physical address, I/O window flag,
//                                 exception code
//   refill_req/refill_vpn         main-TLB request, held until refill_ack
//   refill_ack/refill_found       main-TLB response strobe and hit flag
//   refill_pfn/refill_v/refill_d  main-TLB PFN, valid bit, dirty bit
//   flush                         invalidate every micro-TLB entry
//   miss_count                    saturating micro-TLB miss counter
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module utlb_walker #(
  parameter int ENTRY_ADDR_WIDTH = 2,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_vaddr,
  input  logic                 req_write,
  input  logic                 req_user,
  output logic                 resp_valid,
  output logic [31:0]          resp_paddr,
  output logic                 resp_io,
  output logic [2:0]           resp_exc,
  output logic                 refill_req,
  output logic [19:0]          refill_vpn,
  input  logic                 refill_ack,
  input  logic                 refill_found,
  input  logic [19:0]          refill_pfn,
  input  logic                 refill_v,
  input  logic                 refill_d,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int ENTRY_COUNT = 2 ** ENTRY_ADDR_WIDTH;

  // Walker states
  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_LOOKUP = 2'd1;
  localparam logic [1:0] C_ST_REFILL = 2'd2;
  localparam logic [1:0] C_ST_RESP   = 2'd3;

  // Exception codes
  localparam logic [2:0] C_EXC_NONE     = 3'd0;
  localparam logic [2:0] C_EXC_TLBMISS  = 3'd1;
  localparam logic [2:0] C_EXC_TLBL     = 3'd2;
  localparam logic [2:0] C_EXC_TLBS     = 3'd3;
  localparam logic [2:0] C_EXC_MODIFIED = 3'd4;
  localparam logic [2:0] C_EXC_ADDRERR  = 3'd5;

  // Control state
  logic [1:0]                  r_state;
  logic [31:0]                 r_vaddr;
  logic                        r_write;
  logic                        r_user;
  logic [ENTRY_ADDR_WIDTH-1:0] r_victim;
  logic [CNT_WIDTH-1:0]        r_miss_count;
  logic                        r_resp_valid;
  logic [31:0]                 r_resp_paddr;
  logic                        r_resp_io;
  logic [2:0]                  r_resp_exc;
  logic                        r_refill_req;
  logic [19:0]                 r_refill_vpn;

  // Entry storage. Only the tag valid bits need a reset value; the payload
  // is never consulted while its tag is invalid.
  logic [ENTRY_COUNT-1:0]      r_tag_valid;
  logic [19:0]                 r_vpn [ENTRY_COUNT];
  logic [19:0]                 r_pfn [ENTRY_COUNT];
  logic [ENTRY_COUNT-1:0]      r_v;
  logic [ENTRY_COUNT-1:0]      r_d;

  // Lookup / result datapath
  logic                        w_hit;
  logic [19:0]                 w_hit_pfn;
  logic                        w_hit_v;
  logic                        w_hit_d;
  logic                        w_addrerr;
  logic                        w_unmapped;
  logic                        w_io;
  logic                        w_refill_write;
  logic [31:0]                 w_refill_paddr;
  logic [2:0]                  w_refill_exc;

  // Permission check shared by the hit path and the refill path.
  function automatic logic [2:0] perm_exc(input logic v, input logic d,
                                          input logic wr);
    logic [2:0] exc;
    exc = C_EXC_NONE;
    if (!v) begin
      exc = wr ? C_EXC_TLBS : C_EXC_TLBL;
    end else if (wr && !d) begin
      exc = C_EXC_MODIFIED;
    end
    return exc;
  endfunction

  // Fully associative match against the registered contents. A flush raised
  // in the LOOKUP cycle only takes effect at the clock edge, so the decision
  // made here always reflects pre-flush contents.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_pfn = 20'd0;
    w_hit_v   = 1'b0;
    w_hit_d   = 1'b0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (!w_hit && r_tag_valid[i] && (r_vpn[i] == r_vaddr[31:12])) begin
        w_hit     = 1'b1;
        w_hit_pfn = r_pfn[i];
        w_hit_v   = r_v[i];
        w_hit_d   = r_d[i];
      end
    end
  end

  assign w_addrerr  = r_user & r_vaddr[31];
  assign w_unmapped = (r_vaddr[31:30] == 2'b10);
  assign w_io       = (r_vaddr[31:29] == 3'b101);

  assign w_refill_write = (r_state == C_ST_REFILL) & refill_ack & refill_found;
  assign w_refill_paddr = refill_found ? {refill_pfn, r_vaddr[11:0]} : 32'd0;
  assign w_refill_exc   = refill_found ? perm_exc(refill_v, refill_d, r_write)
                                       : C_EXC_TLBMISS;

  // Walker FSM, response registers, counters and tag valid bits.
  always_ff @(posedge clk) begin
    if (res) begin
      r_state      <= C_ST_IDLE;
      r_vaddr      <= 32'd0;
      r_write      <= 1'b0;
      r_user       <= 1'b0;
      r_victim     <= '0;
      r_miss_count <= '0;
      r_resp_valid <= 1'b0;
      r_resp_paddr <= 32'd0;
      r_resp_io    <= 1'b0;
      r_resp_exc   <= 3'd0;
      r_refill_req <= 1'b0;
      r_refill_vpn <= 20'd0;
      r_tag_valid  <= '0;
    end else begin
      r_resp_valid <= 1'b0;

      // Flush first: a refill write later in this block overrides the
      // cleared bit of the victim entry, leaving the new entry valid.
      if (flush) begin
        r_tag_valid <= '0;
      end

      case (r_state)
        C_ST_IDLE: begin
          if (req_valid) begin
            r_vaddr <= req_vaddr;
            r_write <= req_write;
            r_user  <= req_user;
            r_state <= C_ST_LOOKUP;
          end
        end

        C_ST_LOOKUP: begin
          if (w_addrerr) begin
            r_resp_paddr <= 32'd0;
            r_resp_io    <= 1'b0;
            r_resp_exc   <= C_EXC_ADDRERR;
            r_resp_valid <= 1'b1;
            r_state      <= C_ST_RESP;
          end else if (w_unmapped) begin
            r_resp_paddr <= {3'b000, r_vaddr[28:0]};
            r_resp_io    <= w_io;
            r_resp_exc   <= C_EXC_NONE;
            r_resp_valid <= 1'b1;
            r_state      <= C_ST_RESP;
          end else if (w_hit) begin
            r_resp_paddr <= {w_hit_pfn, r_vaddr[11:0]};
            r_resp_io    <= w_io;
            r_resp_exc   <= perm_exc(w_hit_v, w_hit_d, r_write);
            r_resp_valid <= 1'b1;
            r_state      <= C_ST_RESP;
          end else begin
            if (r_miss_count != {CNT_WIDTH{1'b1}}) begin
              r_miss_count <= r_miss_count + CNT_WIDTH'(1);
            end
            r_refill_req <= 1'b1;
            r_refill_vpn <= r_vaddr[31:12];
            r_state      <= C_ST_REFILL;
          end
        end

        C_ST_REFILL: begin
          if (refill_ack) begin
            r_refill_req <= 1'b0;
            if (refill_found) begin
              r_tag_valid[r_victim] <= 1'b1;
              // ENTRY_COUNT is a power of two, so the wrap is implicit.
              r_victim <= r_victim + ENTRY_ADDR_WIDTH'(1);
            end
            r_resp_paddr <= w_refill_paddr;
            r_resp_io    <= w_io;
            r_resp_exc   <= w_refill_exc;
            r_resp_valid <= 1'b1;
            r_state      <= C_ST_RESP;
          end
        end

        C_ST_RESP: begin
          r_state <= C_ST_IDLE;
        end

        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  // Entry payload, written only by a successful refill. Reset blocks the
  // write so that an abandoned refill leaves no trace.
  always_ff @(posedge clk) begin
    if (!res && w_refill_write) begin
      r_vpn[r_victim] <= r_refill_vpn;
      r_pfn[r_victim] <= refill_pfn;
      r_v[r_victim]   <= refill_v;
      r_d[r_victim]   <= refill_d;
    end
  end

  assign req_ready  = (r_state == C_ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_paddr = r_resp_paddr;
  assign resp_io    = r_resp_io;
  assign resp_exc   = r_resp_exc;
  assign refill_req = r_refill_req;
  assign refill_vpn = r_refill_vpn;
  assign miss_count = r_miss_count;

endmodule

`default_nettype wire
